ysyx_22041412_wb_sched: RTL
===========================

Name: ysyx_22041412_wb_sched

Overview:
Write-back scheduler and scoreboard for the 32x64 integer register file. Two result sources share the register file's single write port: the ALU/EXU path and the LSU load path. The arbiter drives the register file write port (Wen/Rw/BusW) from a register stage. A per-register busy scoreboard blocks issue on RAW/WAW hazards until the producing write has committed.

Parameters:
XLEN, 64, data width of BusW and the source data ports
RR_EN, 1, 1 = round-robin arbitration between ALU and LSU; 0 = fixed priority with ALU winning

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset, asynchronous, active-high
iss_valid  in  1  decode presents an instruction for issue
iss_rd  in  5  destination register of the issuing instruction
iss_rs1  in  5  source register 1
iss_rs2  in  5  source register 2
iss_wr  in  1  issuing instruction writes rd
iss_ready  out  1  issue permitted this cycle (combinational)
flush  in  1  pipeline flush; clears the scoreboard
alu_valid  in  1  ALU result valid
alu_rd  in  5  ALU destination register
alu_data  in  XLEN  ALU result
alu_ready  out  1  ALU result accepted this cycle (combinational grant)
lsu_valid  in  1  LSU load result valid
lsu_rd  in  5  LSU destination register
lsu_data  in  XLEN  LSU result
lsu_ready  out  1  LSU result accepted this cycle (combinational grant)
rf_wen  out  1  register file write enable
rf_rw  out  5  register file write address
rf_busw  out  XLEN  register file write data
busy_cnt  out  6  number of set busy bits
sb_err  out  1  sticky flag: write-back to a register that is not busy

Behaviour:
- Reset values (asynchronous): busy[31:0]=0, rf_wen=0, rf_rw=0, rf_busw=0, busy_cnt=0, sb_err=0, rr pointer=ALU.
- Scoreboard
  - busy[0] is hardwired to 0.
  - iss_ready = !(busy[iss_rs1] | busy[iss_rs2] | (iss_wr & busy[iss_rd])).
  - Reads use the registered bits only; there is no same-cycle bypass.
  - Issue fire = iss_valid & iss_ready.
  - On fire with iss_wr=1 and iss_rd!=0, busy[iss_rd] is set at the next edge.
- Arbitration
  - Exactly one grant per cycle at most.
  - Only one source valid: that source is granted.
  - Both valid, RR_EN=1: the source the pointer selects wins. After any grant, the pointer moves to the non-granted source.
  - Both valid, RR_EN=0: ALU wins.
  - Sources hold valid/rd/data stable until their ready is seen.
- Write stage (1-cycle latency)
  - Grant in cycle N: rf_wen=1, rf_rw=rd, rf_busw=data during cycle N+1. The register file commits at the end of N+1.
  - Granted rd=0: the beat is accepted, but rf_wen=0 in N+1.
  - No grant in N: rf_wen=0 in N+1. rf_rw and rf_busw hold their previous values.
- Busy clear
  - busy[rf_rw] is cleared at the end of the cycle in which rf_wen=1, the same edge as the register file write.
  - The first cycle in which issue can see the register as free is N+2. This guarantees issue reads the committed value.
- Scoreboard error
  - If rf_wen=1 and busy[rf_rw]=0, sb_err is set.
  - sb_err is sticky until rst.
- Simultaneous events
  - Set and clear of the same register on one edge cannot occur legally (WAW blocks issue). If it does occur, set wins.
  - flush and issue fire on the same edge: flush wins, and no bit is set.
  - flush and rf_wen=1: the write still goes to the register file. No bit is cleared (all bits are already 0). sb_err is not raised for writes in the cycle flush is asserted or the cycle after.
- Flush
  - Clears all busy bits at the next edge.
  - Does not cancel the grant registered this cycle. Does not affect the rr pointer.
- busy_cnt is a registered popcount of busy, updated the same edge as busy (range 0..31).

Test Plan:
- Reset mid-operation: rst pulsed asynchronously while rf_wen=1 and busy_cnt=3 -> rf_wen, busy_cnt, sb_err all 0 immediately, before the next clk edge.
- Hazard: issue rd=5 (iss_wr=1) -> next cycle, issue rs1=5 gives iss_ready=0. ALU result rd=5, data 0x1234 granted in N -> rf_wen=1, rf_rw=5, rf_busw=0x1234 in N+1. iss_ready=0 in N+1 and 1 in N+2.
- Contention with RR_EN=1: alu_valid and lsu_valid held high for 4 cycles, distinct rd -> grants ALU, LSU, ALU, LSU. With RR_EN=0 -> ALU every cycle and lsu_ready=0.
- x0 handling: issue rd=0 -> busy_cnt stays 0. LSU result rd=0 -> lsu_ready=1, rf_wen=0 next cycle, sb_err=0.
- Flush: busy rd 3, 7, 9 (busy_cnt=3), flush together with iss_valid rd=10 -> busy_cnt=0 next cycle and busy[10]=0. A later write-back to rd=3 raises sb_err=1.
- Spurious write-back: ALU result rd=12 with busy[12]=0, no flush -> rf_wen=1 and sb_err=1 from N+2, held.

Source files
------------

// File: rtl/ysyx_22041412_wb_sched_if.sv
// Write-back scheduler bundle: issue port, two result sources,
// register file write port and scoreboard status.
interface ysyx_22041412_wb_sched_if #(
    parameter int XLEN = 64
);
    logic            iss_valid;
    logic [4:0]      iss_rd;
    logic [4:0]      iss_rs1;
    logic [4:0]      iss_rs2;
    logic            iss_wr;
    logic            iss_ready;
    logic            flush;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            rf_wen;
    logic [4:0]      rf_rw;
    logic [XLEN-1:0] rf_busw;
    logic [5:0]      busy_cnt;
    logic            sb_err;

    modport master (
        output iss_valid, iss_rd, iss_rs1, iss_rs2, iss_wr, flush,
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  iss_ready, alu_ready, lsu_ready,
        input  rf_wen, rf_rw, rf_busw, busy_cnt, sb_err
    );

    modport slave (
        input  iss_valid, iss_rd, iss_rs1, iss_rs2, iss_wr, flush,
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output iss_ready, alu_ready, lsu_ready,
        output rf_wen, rf_rw, rf_busw, busy_cnt, sb_err
    );
endinterface

// File: rtl/ysyx_22041412_wb_sched.sv
// Write-back scheduler: arbitrates ALU and LSU results onto the single
// register file write port and keeps a per-register busy scoreboard
// that stalls issue on RAW/WAW hazards until the write has committed.
module ysyx_22041412_wb_sched #(
    parameter int XLEN  = 64,
    parameter bit RR_EN = 1'b1
) (
    input logic clk,
    input logic rst,
    ysyx_22041412_wb_sched_if.slave bus
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_LSU = 1'b1
    } rr_ptr_t;

    rr_ptr_t         ptr;
    logic [31:0]     busy;
    logic [31:0]     busy_nxt;
    logic [5:0]      busy_cnt_q;
    logic            sb_err_q;
    logic            flush_d;
    logic            rf_wen_q;
    logic [4:0]      rf_rw_q;
    logic [XLEN-1:0] rf_busw_q;
    logic            grant_alu;
    logic            grant_lsu;
    logic            fire;
    logic            err_set;

    function automatic logic [5:0] popcnt(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    // Grant at most one source; the pointer only matters when both are valid
    always_comb begin
        grant_alu = bus.alu_valid &
                    (!bus.lsu_valid || !RR_EN || (ptr == PTR_ALU));
        grant_lsu = bus.lsu_valid & ~grant_alu;
    end

    // Issue check reads registered busy bits only, so a freed register is
    // visible one cycle after its write commits
    always_comb begin
        bus.iss_ready = !(busy[bus.iss_rs1] | busy[bus.iss_rs2] |
                          (bus.iss_wr & busy[bus.iss_rd]));
        fire          = bus.iss_valid & bus.iss_ready;
    end

    // Next scoreboard: clear on commit, set on issue (set wins), flush wipes all
    always_comb begin
        busy_nxt = busy;
        if (rf_wen_q) begin
            busy_nxt[rf_rw_q] = 1'b0;
        end
        if (fire && bus.iss_wr && (bus.iss_rd != 5'd0)) begin
            busy_nxt[bus.iss_rd] = 1'b1;
        end
        if (bus.flush) begin
            busy_nxt = '0;
        end
        busy_nxt[0] = 1'b0;
        err_set = rf_wen_q & ~busy[rf_rw_q] & ~bus.flush & ~flush_d;
    end

    // Scoreboard state, its popcount and the sticky error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy       <= '0;
            busy_cnt_q <= 6'd0;
            sb_err_q   <= 1'b0;
            flush_d    <= 1'b0;
        end else begin
            busy       <= busy_nxt;
            busy_cnt_q <= popcnt(busy_nxt);
            sb_err_q   <= sb_err_q | err_set;
            flush_d    <= bus.flush;
        end
    end

    // Register the granted beat; x0 is accepted but never written
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q  <= 1'b0;
            rf_rw_q   <= 5'd0;
            rf_busw_q <= '0;
        end else if (grant_alu) begin
            rf_wen_q  <= (bus.alu_rd != 5'd0);
            rf_rw_q   <= bus.alu_rd;
            rf_busw_q <= bus.alu_data;
        end else if (grant_lsu) begin
            rf_wen_q  <= (bus.lsu_rd != 5'd0);
            rf_rw_q   <= bus.lsu_rd;
            rf_busw_q <= bus.lsu_data;
        end else begin
            rf_wen_q  <= 1'b0;
        end
    end

    // Round-robin pointer moves to whichever source lost the last grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= PTR_ALU;
        end else if (grant_alu) begin
            ptr <= PTR_LSU;
        end else if (grant_lsu) begin
            ptr <= PTR_ALU;
        end
    end

    assign bus.alu_ready = grant_alu;
    assign bus.lsu_ready = grant_lsu;
    assign bus.rf_wen    = rf_wen_q;
    assign bus.rf_rw     = rf_rw_q;
    assign bus.rf_busw   = rf_busw_q;
    assign bus.busy_cnt  = busy_cnt_q;
    assign bus.sb_err    = sb_err_q;

endmodule
